// File: rtl/m68k_sdram_controller.sv
// m68k_sdram_controller: owns the SDRAM pins. Runs the power-up init sequence,
// periodic auto-refresh, 8-word burst line fills and byte-masked single writes
// requested by the 68k cache controller.
module m68k_sdram_controller #(
    parameter int unsigned INIT_WAIT        = 5000,
    parameter int unsigned REFRESH_INTERVAL = 375,
    parameter int unsigned T_RCD            = 2,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RFC            = 7,
    parameter int unsigned T_WR             = 2
) (
    input  logic        Clock,
    input  logic        Reset_H,
    input  logic        DramSelect_L,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic        UDS_L,
    input  logic        LDS_L,
    input  logic [31:0] Address,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Dtack_L,
    output logic        Initialised_H,
    output logic        SDram_CKE_H,
    output logic        SDram_CS_L,
    output logic        SDram_RAS_L,
    output logic        SDram_CAS_L,
    output logic        SDram_WE_L,
    output logic [1:0]  SDram_BA,
    output logic [12:0] SDram_Addr,
    output logic [1:0]  SDram_DQM,
    output logic [15:0] SDram_DQ_Out,
    output logic        SDram_DQ_OE_H,
    input  logic [15:0] SDram_DQ_In
);

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned RCNT_W       = $clog2(REFRESH_INTERVAL + 1);
    localparam int unsigned READ_CYCLES  = 10 + T_RP;
    localparam int unsigned WRITE_CYCLES = T_WR + T_RP;

    // {CS_L, RAS_L, CAS_L, WE_L}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [12:0] MODE_WORD = 13'h0223;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MODE,
        S_IDLE,
        S_REFRESH,
        S_ACTIVE,
        S_READ,
        S_WRITE_REC,
        S_WAIT_END
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RCNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic               ref_pend_q, ref_pend_d;

    logic [3:0]         cmd_q, cmd_d;
    logic [1:0]         ba_q, ba_d;
    logic [12:0]        addr_q, addr_d;
    logic [1:0]         dqm_q, dqm_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               oe_q, oe_d;
    logic               dtack_q, dtack_d;
    logic               init_q, init_d;

    logic               req_c;
    logic               wait_last_c;
    logic [9:0]         col_c;
    logic [12:0]        row_c;
    logic [1:0]         bank_c;
    logic               unused_addr_c;

    assign req_c         = ~DramSelect_L & ~AS_L;
    assign col_c         = Address[10:1];
    assign row_c         = Address[23:11];
    assign bank_c        = Address[25:24];
    assign unused_addr_c = ^{Address[31:26], Address[0]};

    // Last cycle of the timed wait in the current state.
    always_comb begin
        wait_last_c = 1'b0;
        case (state_q)
            S_INIT_WAIT: wait_last_c = (cnt_q == CNT_W'(INIT_WAIT - 1));
            S_INIT_PRE:  wait_last_c = (cnt_q == CNT_W'(T_RP));
            S_INIT_REF1: wait_last_c = (cnt_q == CNT_W'(T_RFC));
            S_INIT_REF2: wait_last_c = (cnt_q == CNT_W'(T_RFC));
            S_INIT_MODE: wait_last_c = (cnt_q == CNT_W'(1));
            // Idle re-decides one cycle early so the next command lands T_RFC after REF.
            S_REFRESH:   wait_last_c = (cnt_q == CNT_W'(T_RFC - 2));
            S_ACTIVE:    wait_last_c = (cnt_q == CNT_W'(T_RCD - 1));
            S_READ:      wait_last_c = (cnt_q == CNT_W'(READ_CYCLES - 1));
            S_WRITE_REC: wait_last_c = (cnt_q == CNT_W'(WRITE_CYCLES - 1));
            default:     wait_last_c = 1'b0;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q <= S_INIT_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = wait_last_c ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            S_INIT_WAIT: if (wait_last_c) state_d = S_INIT_PRE;
            S_INIT_PRE:  if (wait_last_c) state_d = S_INIT_REF1;
            S_INIT_REF1: if (wait_last_c) state_d = S_INIT_REF2;
            S_INIT_REF2: if (wait_last_c) state_d = S_INIT_MODE;
            S_INIT_MODE: if (wait_last_c) state_d = S_IDLE;
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pend_q) begin
                    state_d = S_REFRESH;
                end else if (req_c) begin
                    state_d = S_ACTIVE;
                end
            end
            S_REFRESH:   if (wait_last_c) state_d = S_IDLE;
            S_ACTIVE:    if (wait_last_c) state_d = WE_L ? S_READ : S_WRITE_REC;
            S_READ:      if (wait_last_c) state_d = S_WAIT_END;
            S_WRITE_REC: if (wait_last_c) state_d = S_WAIT_END;
            S_WAIT_END: begin
                cnt_d = '0;
                if (!req_c) state_d = S_IDLE;
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    // Output logic: next values of the registered pins and handshakes.
    always_comb begin
        cmd_d    = CMD_NOP;
        ba_d     = ba_q;
        addr_d   = addr_q;
        dqm_d    = 2'b11;
        dq_out_d = dq_out_q;
        oe_d     = 1'b0;
        dtack_d  = 1'b1;
        init_d   = init_q;
        case (state_q)
            S_INIT_WAIT: begin
                if (wait_last_c) begin
                    cmd_d  = CMD_PRE;
                    addr_d = 13'h0400;
                end
            end
            S_INIT_PRE, S_INIT_REF1: begin
                if (wait_last_c) cmd_d = CMD_REF;
            end
            S_INIT_REF2: begin
                if (wait_last_c) begin
                    cmd_d  = CMD_MRS;
                    addr_d = MODE_WORD;
                    ba_d   = 2'b00;
                end
            end
            S_INIT_MODE: begin
                if (wait_last_c) init_d = 1'b1;
            end
            S_IDLE: begin
                if (ref_pend_q) begin
                    cmd_d = CMD_REF;
                end else if (req_c) begin
                    cmd_d  = CMD_ACT;
                    addr_d = row_c;
                    ba_d   = bank_c;
                end
            end
            S_ACTIVE: begin
                if (wait_last_c) begin
                    ba_d = bank_c;
                    if (WE_L) begin
                        // Line fill: aligned 8-word burst with auto-precharge.
                        cmd_d  = CMD_READ;
                        addr_d = {2'b00, 1'b1, col_c[9:3], 3'b000};
                        dqm_d  = 2'b00;
                    end else begin
                        cmd_d    = CMD_WRITE;
                        addr_d   = {2'b00, 1'b1, col_c};
                        dqm_d    = {UDS_L, LDS_L};
                        dq_out_d = DataIn;
                        oe_d     = 1'b1;
                    end
                end
            end
            // Keep DQM low so the burst data is not masked at the pad.
            S_READ:      dqm_d   = 2'b00;
            S_WRITE_REC: dtack_d = 1'b0;
            S_WAIT_END:  dtack_d = ~req_c;
            default: ;
        endcase
    end

    // Refresh interval counter and pending request flag.
    always_comb begin
        ref_cnt_d  = ref_cnt_q + RCNT_W'(1);
        ref_pend_d = ref_pend_q;
        if (cmd_d == CMD_REF) ref_pend_d = 1'b0;
        if (ref_cnt_q == RCNT_W'(REFRESH_INTERVAL - 1)) begin
            ref_cnt_d  = '0;
            ref_pend_d = 1'b1;
        end
    end

    // Refresh counter registers.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    // Registered SDRAM pins and handshakes.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            cmd_q    <= CMD_NOP;
            ba_q     <= 2'b00;
            addr_q   <= '0;
            dqm_q    <= 2'b11;
            dq_out_q <= '0;
            oe_q     <= 1'b0;
            dtack_q  <= 1'b1;
            init_q   <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
            dqm_q    <= dqm_d;
            dq_out_q <= dq_out_d;
            oe_q     <= oe_d;
            dtack_q  <= dtack_d;
            init_q   <= init_d;
        end
    end

    assign {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = cmd_q;
    assign SDram_CKE_H   = 1'b1;
    assign SDram_BA      = ba_q;
    assign SDram_Addr    = addr_q;
    assign SDram_DQM     = dqm_q;
    assign SDram_DQ_Out  = dq_out_q;
    assign SDram_DQ_OE_H = oe_q;
    assign Dtack_L       = dtack_q;
    assign Initialised_H = init_q;
    assign DataOut       = SDram_DQ_In;

endmodule

// File: tb/tb_m68k_sdram_controller.sv
// Directed bench for m68k_sdram_controller: init sequence, table of read/write
// accesses, idle refresh spacing, refresh/access collision and mid-burst reset.
module tb_m68k_sdram_controller;

    localparam int unsigned INIT_WAIT        = 20;
    localparam int unsigned REFRESH_INTERVAL = 100;
    localparam int unsigned T_RCD            = 2;
    localparam int unsigned T_RP             = 2;
    localparam int unsigned T_RFC            = 7;
    localparam int unsigned T_WR             = 2;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    typedef struct {
        logic        we_l;
        logic        uds_l;
        logic        lds_l;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [12:0] exp_row;
        logic [1:0]  exp_ba;
        logic [12:0] exp_cas_addr;
        logic [1:0]  exp_dqm;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset_H;
    logic        DramSelect_L;
    logic        AS_L;
    logic        WE_L;
    logic        UDS_L;
    logic        LDS_L;
    logic [31:0] Address;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Dtack_L;
    logic        Initialised_H;
    logic        SDram_CKE_H;
    logic        SDram_CS_L;
    logic        SDram_RAS_L;
    logic        SDram_CAS_L;
    logic        SDram_WE_L;
    logic [1:0]  SDram_BA;
    logic [12:0] SDram_Addr;
    logic [1:0]  SDram_DQM;
    logic [15:0] SDram_DQ_Out;
    logic        SDram_DQ_OE_H;
    logic [15:0] SDram_DQ_In;

    logic [3:0]  cmd;
    assign cmd = {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L};

    int cyc     = 0;
    int n_check = 0;
    int n_pass  = 0;
    vec_t vecs[5];

    always #5 Clock = ~Clock;

    m68k_sdram_controller #(
        .INIT_WAIT       (INIT_WAIT),
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .T_RCD           (T_RCD),
        .T_RP            (T_RP),
        .T_RFC           (T_RFC),
        .T_WR            (T_WR)
    ) dut (
        .Clock        (Clock),
        .Reset_H      (Reset_H),
        .DramSelect_L (DramSelect_L),
        .AS_L         (AS_L),
        .WE_L         (WE_L),
        .UDS_L        (UDS_L),
        .LDS_L        (LDS_L),
        .Address      (Address),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .Dtack_L      (Dtack_L),
        .Initialised_H(Initialised_H),
        .SDram_CKE_H  (SDram_CKE_H),
        .SDram_CS_L   (SDram_CS_L),
        .SDram_RAS_L  (SDram_RAS_L),
        .SDram_CAS_L  (SDram_CAS_L),
        .SDram_WE_L   (SDram_WE_L),
        .SDram_BA     (SDram_BA),
        .SDram_Addr   (SDram_Addr),
        .SDram_DQM    (SDram_DQM),
        .SDram_DQ_Out (SDram_DQ_Out),
        .SDram_DQ_OE_H(SDram_DQ_OE_H),
        .SDram_DQ_In  (SDram_DQ_In)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    // Step until the given command is on the pins; counts refreshes passed on the way.
    task automatic wait_cmd(input string name, input logic [3:0] c, input int budget,
                            output int at, output int refs);
        bit found;
        found = 1'b0;
        at    = -1;
        refs  = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (cmd == c) begin
                found = 1'b1;
                at    = cyc;
            end else if (cmd == C_REF) begin
                refs++;
            end
        end
        chk({name, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic release_bus();
        DramSelect_L = 1'b1;
        AS_L         = 1'b1;
        WE_L         = 1'b1;
        UDS_L        = 1'b1;
        LDS_L        = 1'b1;
        SDram_DQ_In  = 16'h0000;
    endtask

    task automatic drive_req(input vec_t v);
        DramSelect_L = 1'b0;
        AS_L         = 1'b0;
        WE_L         = v.we_l;
        UDS_L        = v.uds_l;
        LDS_L        = v.lds_l;
        Address      = v.addr;
        DataIn       = v.wdata;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_nop"}, 32'(cmd), 32'(C_NOP));
        chk({tag, "_cke"},     32'(SDram_CKE_H), 32'd1);
        chk({tag, "_dqm"},     32'(SDram_DQM), 32'd3);
        chk({tag, "_addr"},    32'(SDram_Addr), 32'd0);
        chk({tag, "_ba"},      32'(SDram_BA), 32'd0);
        chk({tag, "_oe"},      32'(SDram_DQ_OE_H), 32'd0);
        chk({tag, "_dqout"},   32'(SDram_DQ_Out), 32'd0);
        chk({tag, "_dtack"},   32'(Dtack_L), 32'd1);
        chk({tag, "_init"},    32'(Initialised_H), 32'd0);
    endtask

    // r is the cycle of the last edge that sampled Reset_H=1.
    task automatic check_init(input int r);
        int tp, t1, t2, tm, d;
        wait_cmd("init_pre", C_PRE, INIT_WAIT + 10, tp, d);
        chk("init_pre_delay", 32'(tp - r), 32'(INIT_WAIT));
        chk("init_pre_a10", 32'(SDram_Addr[10]), 32'd1);
        wait_cmd("init_ref1", C_REF, 20, t1, d);
        chk("init_pre_to_ref1", 32'(t1 - tp), 32'(T_RP + 1));
        wait_cmd("init_ref2", C_REF, 20, t2, d);
        chk("init_ref_spacing_ge_trfc", 32'((t2 - t1) >= int'(T_RFC)), 32'd1);
        wait_cmd("init_mrs", C_MRS, 20, tm, d);
        chk("init_mrs_addr", 32'(SDram_Addr), 32'h223);
        chk("init_mrs_ba", 32'(SDram_BA), 32'd0);
        chk("init_flag_at_mrs", 32'(Initialised_H), 32'd0);
        step();
        chk("init_flag_mrs_p1", 32'(Initialised_H), 32'd0);
        step();
        chk("init_flag_mrs_p2", 32'(Initialised_H), 32'd1);
    endtask

    // Runs from the cycle where ACTIVE is on the pins to the end of the access.
    task automatic access_body(input vec_t v, input int idx);
        int nonnop, bad, dt_low, dt_high;
        bit seen;
        logic [15:0] w;
        chk("act_row", 32'(SDram_Addr), 32'(v.exp_row));
        chk("act_ba", 32'(SDram_BA), 32'(v.exp_ba));
        nonnop = 0;
        for (int i = 0; i < int'(T_RCD) - 1; i++) begin
            step();
            if (cmd != C_NOP) nonnop++;
        end
        step();
        chk("rcd_gap_nops", 32'(nonnop), 32'd0);
        chk("rw_cmd", 32'(cmd), 32'(v.we_l ? C_RD : C_WR));
        chk("rw_addr", 32'(SDram_Addr), 32'(v.exp_cas_addr));
        chk("rw_ba", 32'(SDram_BA), 32'(v.exp_ba));
        chk("rw_dqm", 32'(SDram_DQM), 32'(v.exp_dqm));
        if (!v.we_l) begin
            chk("wr_dqout", 32'(SDram_DQ_Out), 32'(v.wdata));
            chk("wr_oe", 32'(SDram_DQ_OE_H), 32'd1);
            step();
            chk("wr_oe_one_cycle", 32'(SDram_DQ_OE_H), 32'd0);
            chk("wr_dtack_first_rec", 32'(Dtack_L), 32'd0);
            dt_high = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (Dtack_L) dt_high++;
            end
            chk("wr_dtack_held", 32'(dt_high), 32'd0);
        end else begin
            chk("rd_oe", 32'(SDram_DQ_OE_H), 32'd0);
            bad    = 0;
            dt_low = 0;
            for (int k = 1; k <= 9; k++) begin
                step();
                if (k >= 2) begin
                    w = 16'(16'hD000 + 16'(idx * 16'h0100) + 16'(k));
                    SDram_DQ_In = w;
                    #1;
                    if (DataOut !== w) bad++;
                end
                if (!Dtack_L) dt_low++;
            end
            chk("rd_burst_dataout", 32'(bad), 32'd0);
            chk("rd_dtack_high_in_burst", 32'(dt_low), 32'd0);
            SDram_DQ_In = 16'h0000;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step();
                if (!Dtack_L) seen = 1'b1;
            end
            chk("rd_dtack_asserted", 32'(seen), 32'd1);
            dt_high = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (Dtack_L) dt_high++;
            end
            chk("rd_dtack_held", 32'(dt_high), 32'd0);
        end
        release_bus();
        step();
        chk("dtack_release", 32'(Dtack_L), 32'd1);
    endtask

    task automatic do_access(input vec_t v, input int idx);
        int ta, refs;
        drive_req(v);
        wait_cmd("act", C_ACT, 30, ta, refs);
        access_body(v, idx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int r, r0, last, nref, gap_bad, tr, ta, refs, d, target;

        //            we    uds   lds   address        wdata     row       ba    cas addr  dqm
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0123_4566, 16'h0000, 13'h0468, 2'd1, 13'h06B0, 2'b00};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0200_0ABC, 16'hBEEF, 13'h0001, 2'd2, 13'h055E, 2'b01};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h03FF_FFFE, 16'h0000, 13'h1FFF, 2'd3, 13'h07F8, 2'b00};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'hFC00_0002, 16'h1234, 13'h0000, 2'd0, 13'h0401, 2'b10};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 16'hA5A5, 13'h0000, 2'd0, 13'h0400, 2'b00};

        Reset_H = 1'b1;
        Address = 32'h0;
        DataIn  = 16'h0;
        release_bus();
        step();
        step();
        check_reset_vals("rst0");
        r = cyc;
        Reset_H = 1'b0;
        check_init(r);

        for (int i = 0; i < 5; i++) do_access(vecs[i], i);

        // Idle refresh spacing, aligned on two consecutive refreshes.
        wait_cmd("sync_ref_a", C_REF, 3 * REFRESH_INTERVAL, d, refs);
        wait_cmd("sync_ref_b", C_REF, 2 * REFRESH_INTERVAL, r0, refs);
        last    = r0;
        nref    = 0;
        gap_bad = 0;
        for (int i = 0; i < 3 * int'(REFRESH_INTERVAL); i++) begin
            step();
            if (cmd == C_REF) begin
                nref++;
                if (cyc - last != int'(REFRESH_INTERVAL)) gap_bad++;
                last = cyc;
            end
        end
        chk("idle_refresh_count", 32'(nref), 32'd3);
        chk("idle_refresh_gap", 32'(gap_bad), 32'd0);

        // Request appears in Idle together with the next pending refresh.
        target = last + int'(REFRESH_INTERVAL) - 1;
        while (cyc < target) step();
        drive_req(vecs[0]);
        step();
        chk("coinc_ref_first", 32'(cmd), 32'(C_REF));
        tr = cyc;
        wait_cmd("coinc_act", C_ACT, 20, ta, refs);
        chk("coinc_act_delay", 32'(ta - tr), 32'(T_RFC));
        chk("coinc_no_double_ref", 32'(refs), 32'd0);
        access_body(vecs[0], 0);

        // Reset four cycles into a read burst.
        drive_req(vecs[2]);
        wait_cmd("mid_rd", C_RD, 40, d, refs);
        for (int i = 0; i < 4; i++) step();
        Reset_H = 1'b1;
        step();
        check_reset_vals("rst_mid");
        r = cyc;
        Reset_H = 1'b0;
        release_bus();
        check_init(r);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
